multi_clk_div: RTL and testbench

MULTI_CLK_DIV -- requirements
Module: multi_clk_div

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/div_chan.sv | 135 +++++++++++++
 rtl/multi_clk_div.sv | 66 ++++++
 tb/tb_multi_clk_div.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the multi-channel clock divider.
// Used by div_chan and multi_clk_div; CLK_DIV_SHADOW_EN selects the shadowed divisor load.
package clk_div_pkg;

   localparam int NCH_DEF = 4;
   localparam int DW_DEF  = 16;

   // A channel runs whenever its divisor register is non-zero.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chan_state_e;

endpackage

// File: rtl/div_chan.sv
// One divider channel: divisor D, up-counter C, registered output Q and tick.
// CLK_DIV_SHADOW_EN defined: loads go to a shadow register swapped in at the next wrap.
module div_chan
   import clk_div_pkg::*;
#(
   parameter int DW = DW_DEF
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_en,
   input  logic          i_ld,
   input  logic [DW-1:0] i_ld_div,
   output logic          o_q,
   output logic          o_tick,
   output logic          o_shadow_full,
   output chan_state_e   o_state
);

   logic [DW-1:0] r_div;
   logic [DW-1:0] r_cnt;
   logic          r_q;
   logic          r_tick;

   logic [DW-1:0] w_div_nxt;
   logic [DW-1:0] w_cnt_nxt;
   logic          w_q_nxt;
   logic          w_tick_nxt;
   logic          w_wrap;
   chan_state_e   w_state;

   // C never exceeds D-1, so D = 2^DW-1 cannot overflow the counter.
   always_comb begin
      w_state = (r_div != '0) ? ST_RUN : ST_IDLE;
      w_wrap  = (w_state == ST_RUN) && i_en && (r_cnt == (r_div - DW'(1)));
   end

`ifdef CLK_DIV_SHADOW_EN
   logic [DW-1:0] r_shadow;
   logic          r_full;
   logic [DW-1:0] w_shadow_nxt;
   logic          w_full_nxt;

   always_comb begin
      w_div_nxt    = r_div;
      w_cnt_nxt    = r_cnt;
      w_q_nxt      = r_q;
      w_tick_nxt   = 1'b0;
      w_shadow_nxt = r_shadow;
      w_full_nxt   = r_full;
      if (r_full && ((w_state == ST_IDLE) || !i_en)) begin
         // Nothing is counting, so the pending divisor can land without a toggle.
         w_div_nxt  = r_shadow;
         w_cnt_nxt  = '0;
         w_full_nxt = 1'b0;
      end else if (w_state == ST_IDLE) begin
         w_cnt_nxt = '0;
      end else if (i_en) begin
         if (w_wrap) begin
            w_q_nxt    = ~r_q;
            w_tick_nxt = 1'b1;
            w_cnt_nxt  = '0;
            if (r_full) begin
               w_div_nxt  = r_shadow;
               w_full_nxt = 1'b0;
            end
         end else begin
            w_cnt_nxt = r_cnt + DW'(1);
         end
      end
      if (i_ld) begin
         w_shadow_nxt = i_ld_div;
         w_full_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= '0;
         r_full   <= 1'b0;
      end else begin
         r_shadow <= w_shadow_nxt;
         r_full   <= w_full_nxt;
      end
   end

   assign o_shadow_full = r_full;
`else
   always_comb begin
      w_div_nxt  = r_div;
      w_cnt_nxt  = r_cnt;
      w_q_nxt    = r_q;
      w_tick_nxt = 1'b0;
      if (i_ld) begin
         // Immediate restart; a zero divisor parks the channel with Q held.
         w_div_nxt = i_ld_div;
         w_cnt_nxt = '0;
         if (i_ld_div != '0) begin
            w_q_nxt = 1'b0;
         end
      end else if (w_state == ST_IDLE) begin
         w_cnt_nxt = '0;
      end else if (i_en) begin
         if (w_wrap) begin
            w_q_nxt    = ~r_q;
            w_tick_nxt = 1'b1;
            w_cnt_nxt  = '0;
         end else begin
            w_cnt_nxt = r_cnt + DW'(1);
         end
      end
   end

   assign o_shadow_full = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div  <= '0;
         r_cnt  <= '0;
         r_q    <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= w_div_nxt;
         r_cnt  <= w_cnt_nxt;
         r_q    <= w_q_nxt;
         r_tick <= w_tick_nxt;
      end
   end

   assign o_q     = r_q;
   assign o_tick  = r_tick;
   assign o_state = w_state;

endmodule

// File: rtl/multi_clk_div.sv
// NCH independent 50%-duty clock dividers sharing one divisor-load port.
// CLK_DIV_SHADOW_EN defined: loads are shadowed per channel and swapped at the next wrap.
module multi_clk_div
   import clk_div_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int DW  = DW_DEF,
   parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] en,
   input  logic           ld_valid,
   output logic           ld_ready,
   input  logic [CW-1:0]  ld_ch,
   input  logic [DW-1:0]  ld_div,
   output logic [NCH-1:0] div_out,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] dbg_run
);

   logic [NCH-1:0] w_full;
   logic [NCH-1:0] w_ld;
   logic           w_sel_full;
   chan_state_e    w_state [NCH];

   // Load handshake: a load transfers on a rising edge where ld_valid && ld_ready.
   // ld_ready drops during reset and while the addressed channel's shadow is full;
   // an out-of-range ld_ch is always ready and the load is dropped.
   always_comb begin
      w_sel_full = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (ld_ch == CW'(i)) begin
            w_sel_full = w_full[i];
         end
      end
   end

   assign ld_ready = !rst && !w_sel_full;

   always_comb begin
      w_ld = '0;
      for (int i = 0; i < NCH; i++) begin
         w_ld[i] = ld_valid && ld_ready && (ld_ch == CW'(i));
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      div_chan #(
         .DW (DW)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .i_en          (en[g]),
         .i_ld          (w_ld[g]),
         .i_ld_div      (ld_div),
         .o_q           (div_out[g]),
         .o_tick        (tick[g]),
         .o_shadow_full (w_full[g]),
         .o_state       (w_state[g])
      );
      assign dbg_run[g] = (w_state[g] == ST_RUN);
   end

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div against a countdown-based reference model.
// The model follows CLK_DIV_SHADOW_EN the same way the design build does.
module tb_multi_clk_div;

   localparam int NCH = 5;
   localparam int DW  = 8;
   localparam int CW  = 3;
   localparam int W   = 3 * NCH;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] en;
   logic           ld_valid;
   logic           ld_ready;
   logic [CW-1:0]  ld_ch;
   logic [DW-1:0]  ld_div;
   logic [NCH-1:0] div_out;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] dbg_run;

   int total = 0;
   int bad   = 0;

   // Reference state: divisor, cycles left until the next toggle, level, shadow.
   int md  [NCH];
   int rem [NCH];
   int mq  [NCH];
   int msf [NCH];
   int msv [NCH];
   logic [W-1:0] exp_q[$];

   multi_clk_div #(
      .NCH (NCH),
      .DW  (DW),
      .CW  (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_ch    (ld_ch),
      .ld_div   (ld_div),
      .div_out  (div_out),
      .tick     (tick),
      .dbg_run  (dbg_run)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_ready();
      if (rst) return 1'b0;
      if (int'(ld_ch) >= NCH) return 1'b1;
      return (msf[ld_ch] == 0);
   endfunction

   task automatic model_step(input logic acc);
      logic [NCH-1:0] eq, et, er;
      for (int ch = 0; ch < NCH; ch++) begin
         bit ld;
         int v;
         et[ch] = 1'b0;
         ld = acc && (int'(ld_ch) == ch);
         v  = int'(ld_div);
         if (rst) begin
            md[ch] = 0; rem[ch] = 0; mq[ch] = 0; msf[ch] = 0; msv[ch] = 0;
         end else begin
`ifdef CLK_DIV_SHADOW_EN
            if (msf[ch] != 0 && (md[ch] == 0 || !en[ch])) begin
               md[ch] = msv[ch]; rem[ch] = msv[ch]; msf[ch] = 0;
            end else if (md[ch] != 0 && en[ch]) begin
               rem[ch]--;
               if (rem[ch] == 0) begin
                  mq[ch] ^= 1; et[ch] = 1'b1;
                  if (msf[ch] != 0) begin
                     md[ch] = msv[ch]; msf[ch] = 0;
                  end
                  rem[ch] = md[ch];
               end
            end
            if (ld) begin
               msv[ch] = v; msf[ch] = 1;
            end
`else
            if (ld) begin
               md[ch] = v; rem[ch] = v;
               if (v != 0) mq[ch] = 0;
            end else if (md[ch] != 0 && en[ch]) begin
               rem[ch]--;
               if (rem[ch] == 0) begin
                  mq[ch] ^= 1; et[ch] = 1'b1; rem[ch] = md[ch];
               end
            end
`endif
         end
         eq[ch] = mq[ch][0];
         er[ch] = (md[ch] != 0);
      end
      exp_q.push_back({er, et, eq});
   endtask

   // One clock: check ready for the driven inputs, advance model and DUT, compare outputs.
   task automatic cycle();
      logic         acc;
      logic [W-1:0] e;
      #1;
      check("ld_ready", 32'(ld_ready), 32'(model_ready()));
      acc = ld_valid && model_ready();
      @(posedge clk);
      model_step(acc);
      #1;
      e = exp_q.pop_front();
      check("div_out", 32'(div_out), 32'(e[NCH-1:0]));
      check("tick",    32'(tick),    32'(e[2*NCH-1:NCH]));
      check("dbg_run", 32'(dbg_run), 32'(e[3*NCH-1:2*NCH]));
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic load(input int ch, input int d);
      ld_valid = 1'b1;
      ld_ch    = CW'(ch);
      ld_div   = DW'(d);
      cycle();
      ld_valid = 1'b0;
   endtask

   // Runs n cycles and checks every spacing between consecutive ticks of one channel.
   task automatic run_gap(input int ch, input int n, input int gap);
      int last = -1;
      for (int k = 0; k < n; k++) begin
         cycle();
         if (tick[ch]) begin
            if (last >= 0) check("tick_gap", 32'(k - last), 32'(gap));
            last = k;
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = '0; ld_valid = 1'b0; ld_ch = '0; ld_div = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         md[ch] = 0; rem[ch] = 0; mq[ch] = 0; msf[ch] = 0; msv[ch] = 0;
      end
      run(3);
      rst = 1'b0;
      run(2);

      // ch0 divide by 3, then ch1 divide by 1
      en = '1;
      load(0, 3);
      run_gap(0, 14, 3);
      load(1, 1);
      run(6);

      // freeze ch0 for 4 cycles mid-period
      run(1);
      en[0] = 1'b0;
      run(4);
      en[0] = 1'b1;
      run(10);

      // ch2 divide by 4, re-load 2 mid-period; ld_ch stays on ch2 to watch ld_ready
      load(2, 4);
      run(6);
      load(2, 2);
      ld_ch = 3'd2;
      run(14);

      // zero divisor stops ch3; out-of-range load is dropped
      load(3, 5);
      run(7);
      load(3, 0);
      run(10);
      load(NCH, 7);
      run(5);
      load(7, 2);
      run(3);

      // maximum divisor on ch4
      load(4, 255);
      run_gap(4, 520, 255);

      // back-to-back loads to different channels
      load(0, 2);
      load(1, 3);
      load(2, 5);
      run(12);

      // randomized traffic
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) en = NCH'($urandom_range(0, 31));
         ld_valid = ($urandom_range(0, 4) == 0);
         ld_ch    = CW'($urandom_range(0, 7));
         ld_div   = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 255))
                                                 : DW'($urandom_range(0, 6));
         rst      = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0; ld_valid = 1'b0;

      // single-cycle reset in the middle of running periods, with a load offered
      en = '1;
      for (int ch = 0; ch < NCH; ch++) load(ch, ch + 3);
      run(5);
      rst = 1'b1; ld_valid = 1'b1; ld_ch = 3'd1; ld_div = 8'd2;
      cycle();
      rst = 1'b0; ld_valid = 1'b0;
      run(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
